// File: rtl/round_ctrl_pkg.sv
// round_ctrl shared types: cipher direction codes and controller state.
// Optional abort feature: ROUND_CTRL_ABORT_EN.
package round_ctrl_pkg;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

endpackage

// File: rtl/round_ctrl_if.sv
// Handshake bundle between load logic and the round controller.
// ROUND_CTRL_ABORT_EN adds abort/aborted.
interface round_ctrl_if #(
  parameter int RC_W = 5
);
  logic            start;
  logic            mode;
  logic            adv;
  logic            act;
  logic            first;
  logic            last;
  logic            ready;
  logic            mode_q;
  logic [RC_W-1:0] rc;
`ifdef ROUND_CTRL_ABORT_EN
  logic            abort;
  logic            aborted;

  modport master (
    output start, mode, adv, abort,
    input  act, first, last, ready,
    input  mode_q, rc, aborted
  );
  modport slave (
    input  start, mode, adv, abort,
    output act, first, last, ready,
    output mode_q, rc, aborted
  );
`else
  modport master (
    output start, mode, adv,
    input  act, first, last, ready,
    input  mode_q, rc
  );
  modport slave (
    input  start, mode, adv,
    output act, first, last, ready,
    output mode_q, rc
  );
`endif
endinterface

// File: rtl/round_cnt.sv
// Loadable up/down round counter that parks at its terminal value.
module round_cnt #(
  parameter int RC_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [RC_W-1:0] load_val,
  input  logic            dn,
  input  logic            step,
  input  logic [RC_W-1:0] final_val,
  output logic [RC_W-1:0] rc,
  output logic            term
);

  assign term = (rc == final_val);

  always_ff @(posedge clk) begin
    if (rst) begin
      rc <= '0;
    end else if (load) begin
      rc <= load_val;
    end else if (step && !term) begin
      rc <= dn ? rc - RC_W'(1) : rc + RC_W'(1);
    end
  end

endmodule

// File: rtl/round_ctrl.sv
// Block-cipher round sequencer: enc/dec round index, stall, ready pulse.
// Optional abort path enabled by ROUND_CTRL_ABORT_EN.
module round_ctrl
  import round_ctrl_pkg::*;
#(
  parameter int ROUNDS = 32,
  parameter int RC_W   = 5
) (
  input logic         CK,
  input logic         RN,
  round_ctrl_if.slave bus
);

  if (ROUNDS < 2 || (1 << RC_W) < ROUNDS) begin : g_cfg_err
    $error("round_ctrl: ROUNDS must be >= 2 and fit in RC_W bits");
  end

  localparam logic [RC_W-1:0] RC_MAX = RC_W'(ROUNDS - 1);

  state_t          state;
  state_t          state_n;
  logic            mode_q;
  logic            ready;
  logic            act;
  logic            term;
  logic            fin;
  logic            abort_hit;
  logic            load;
  logic [RC_W-1:0] load_val;
  logic [RC_W-1:0] final_val;
  logic [RC_W-1:0] first_val;
  logic [RC_W-1:0] rc;

  assign act       = (state == RUN);
  assign final_val = (mode_q == MODE_DEC) ? '0 : RC_MAX;
  assign first_val = (mode_q == MODE_DEC) ? RC_MAX : '0;
  assign fin       = act && term && bus.adv;

`ifdef ROUND_CTRL_ABORT_EN
  logic aborted;
  // start outranks abort, so a simultaneous pair is a plain restart
  assign abort_hit   = bus.abort && act && !bus.start;
  assign bus.aborted = aborted;
`else
  assign abort_hit = 1'b0;
`endif

  always_comb begin
    state_n  = state;
    load     = 1'b0;
    load_val = '0;
    if (bus.start) begin
      state_n  = RUN;
      load     = 1'b1;
      load_val = (bus.mode == MODE_DEC) ? RC_MAX : '0;
    end else if (abort_hit) begin
      state_n = IDLE;
      load    = 1'b1;
    end else if (fin) begin
      state_n = IDLE;
    end
  end

  always_ff @(posedge CK) begin
    if (RN) begin
      state  <= IDLE;
      mode_q <= MODE_ENC;
      ready  <= 1'b0;
    end else begin
      state <= state_n;
      ready <= fin && !abort_hit;
      if (bus.start) begin
        mode_q <= bus.mode;
      end
    end
  end

`ifdef ROUND_CTRL_ABORT_EN
  always_ff @(posedge CK) begin
    if (RN) begin
      aborted <= 1'b0;
    end else begin
      aborted <= abort_hit;
    end
  end
`endif

  round_cnt #(
    .RC_W(RC_W)
  ) u_cnt (
    .clk      (CK),
    .rst      (RN),
    .load     (load),
    .load_val (load_val),
    .dn       (mode_q),
    .step     (act && bus.adv),
    .final_val(final_val),
    .rc       (rc),
    .term     (term)
  );

  assign bus.act    = act;
  assign bus.first  = act && (rc == first_val);
  assign bus.last   = act && term;
  assign bus.ready  = ready;
  assign bus.mode_q = mode_q;
  assign bus.rc     = rc;

endmodule

// File: doc/round_ctrl.md
# round_ctrl

Parametrised round controller for the block-cipher datapath. It sequences a configurable number of rounds on `start`, supports both encryption and decryption directions, and accepts an advance/stall qualifier from the datapath. It drives the round index `rc` to the round-function and key-schedule logic, and issues a one-cycle `ready` when the final round retires. It sits between the host-side load logic and the round datapath.

## Interface
- `ROUNDS`, 32: number of rounds per block; legal range ≥ 2.
- `RC_W`, 5: width of `rc`; 2^RC_W ≥ ROUNDS is required (elaboration-time check).
- `CK` in 1: single clock, rising edge.
- `RN` in 1: reset, synchronous, active-high.
- `start` in 1: begin (or restart) a block.
- `mode` in 1: sampled with `start`. 0 = encrypt, rc counts up 0 → ROUNDS-1. 1 = decrypt, rc counts down ROUNDS-1 → 0.
- `adv` in 1: datapath accepts the current round this cycle; when low, everything holds.
- `act` out 1: round sequence in progress.
- `first` out 1: `act` && rc == initial value for the latched mode.
- `last` out 1: `act` && rc == final value for the latched mode.
- `ready` out 1: one-cycle pulse, the cycle after the last round retires.
- `mode_q` out 1: mode latched at `start`.
- `rc` out RC_W: current round index.

## Operation
- States: IDLE (`act`=0) and RUN (`act`=1). A round retires in a cycle with `act && adv`.
- Reset (RN=1 at an edge):
  - `act`=0, `rc`=0, `mode_q`=0, `ready`=0.
  - Reset overrides every other input, including `start`.
  - Reset during RUN: no `ready` is produced.
- `start`, in any state:
  - Next cycle: `act`=1, `mode_q`=`mode`, `rc`=0 (enc) or ROUNDS-1 (dec).
  - `start` during RUN restarts the sequence; the interrupted block produces no `ready`.
- In RUN, a retiring non-final round steps `rc`: +1 (enc) or -1 (dec).
- In RUN with `adv`=0: `rc` and `act` hold.
- Final round retires (`last && adv`):
  - Next cycle: `act`=0, `ready`=1.
  - `rc` holds its final value.
  - `ready` = register of (`last && adv`), so it is always exactly one cycle wide.
- `start` in the same cycle as the final retirement:
  - `ready` still pulses next cycle.
  - The new run also begins next cycle (`act` stays 1, `rc` reloads).
- Arithmetic:
  - `rc` never wraps. The step is suppressed at the final value.
  - Unused `rc` codes ≥ ROUNDS are unreachable.
- In IDLE, `adv` is ignored. `first` and `last` are 0 whenever `act`=0.
- `first` and `last` are combinational from registered state; neither depends combinationally on `start` or `adv`.

## Timing
- `start` at edge t → `act`=1 and `rc`=initial value visible after t.
- With `adv` held high, `last`=1 during cycle t+ROUNDS-1. After that edge, `act`=0 and `ready`=1 for exactly one cycle.
- Start-to-ready latency = ROUNDS + 1 cycles, plus one cycle per cycle with `adv`=0 during RUN.
- Back-to-back blocks: `start` may be asserted during the `last` cycle with zero bubble.

## Configuration
- Macro: `ROUND_CTRL_ABORT_EN`.
- Defined:
  - Adds input `abort` (1 bit) and output `aborted` (1-cycle pulse).
  - `abort` in RUN → next cycle `act`=0, `rc`=0, `aborted`=1, no `ready`.
  - Priority: `RN` > `start` > `abort`.
  - `abort` in the same cycle as the final retirement: `ready` is suppressed and `aborted` pulses.
  - `abort` in IDLE: ignored, no pulse.
- Undefined: `abort` and `aborted` ports are absent; behaviour is as above without them.

## Structure
- Package `round_ctrl_pkg`: `MODE_ENC`/`MODE_DEC` constants and the IDLE/RUN state type.
- Sub-module `round_cnt`:
  - Loadable up/down counter, RC_W wide, with load value, direction, step enable and terminal-value compare.
  - Instantiated once; the top holds the state, `mode_q` and the `ready` register.

## Test plan
- Reset: RN=1 for 2 cycles, with `start`=1 during reset → `act`=0, `rc`=0, `ready`=0; no run begins.
- Encrypt, ROUNDS=32, `adv`=1: `start` at t → `rc` 0..31 over t+1..t+32, `first` at rc=0, `last` at rc=31, `ready` only at t+33.
- Decrypt, ROUNDS=10, RC_W=4: `rc` 9..0, `last` at rc=0, `ready` after 11 cycles; `mode_q`=1 throughout.
- Stall: `adv` low for 3 cycles at rc=5 → `rc` holds at 5, `ready` arrives 3 cycles late, exactly one pulse.
- Restart and back-to-back:
  - `start` at rc=12 → `rc`=0 next cycle, no `ready` for the first block.
  - `start` on the `last` cycle → `ready` pulses and `act` stays 1 with `rc`=0.
- With `ROUND_CTRL_ABORT_EN`:
  - `abort` at rc=7 → `aborted` pulse, `act`=0, `rc`=0, no `ready`.
  - `abort`+`start` in the same cycle → restart and no `aborted`.
